data_mem_mmio: RTL and testbench

Parametrised RV32I data memory with memory-mapped I/O, successor to the zero-delay data RAM in the core's memory stage. Adds byte/half/word stores with lane enables, signed/unsigned load extension, misalignment faults, registered one-cycle read latency, and NUM_IN/NUM_OUT I/O word channels. Input channels carry sticky change-event flags that drive an interrupt line. It sits between the load/store unit and the board I/O.

---
 rtl/dmem_pkg.sv | 61 ++++++
 rtl/data_mem_mmio_if.sv | 18 +
 rtl/dmem_ram_bank.sv | 27 ++
 rtl/data_mem_mmio.sv | 122 ++++++++++++
 tb/tb_data_mem_mmio.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32I data memory: funct3 codes, lane enables,
// store lane replication and load extension.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only make sense for loads.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = !we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: misaligned = off[0];
            F3_W:        misaligned = (off != 2'b00);
            default:     misaligned = 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B, F3_BU: byte_en = 4'b0001 << off;
            F3_H, F3_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
            F3_W:        byte_en = 4'b1111;
            default:     byte_en = 4'b0000;
        endcase
    endfunction

    // Replicating the right-aligned data lets the lane enable pick the target lane.
    function automatic logic [31:0] store_align(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B, F3_BU: store_align = {4{d[7:0]}};
            F3_H, F3_HU: store_align = {2{d[15:0]}};
            default:     store_align = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            F3_B:    load_extend = {{24{b[7]}}, b};
            F3_BU:   load_extend = {24'h0, b};
            F3_H:    load_extend = {{16{h[15]}}, h};
            F3_HU:   load_extend = {16'h0, h};
            default: load_extend = w;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_mmio_if.sv
// Load/store unit to data memory bus.
interface data_mem_mmio_if #(
    parameter int ADDR_W = 8
);
    // req is sampled on every rising edge with no backpressure; exactly one
    // cycle later ack pulses for one cycle with rdata/fault for that request.
    logic              req;
    logic              we;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              fault;

    modport master (output req, we, funct3, addr, wdata, input ack, rdata, fault);
    modport slave  (input req, we, funct3, addr, wdata, output ack, rdata, fault);
endinterface

// File: rtl/dmem_ram_bank.sv
// Word-organised synchronous RAM with per-byte write enables and registered read.
module dmem_ram_bank #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [31:0]   wdata_i,
    input  logic          re_i,
    output logic [31:0]   rdata_o
);
    logic [31:0] mem [2**AW];
    logic [31:0] rd_q;

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
        if (re_i) rd_q <= mem[addr_i];
    end

    assign rdata_o = rd_q;
endmodule

// File: rtl/data_mem_mmio.sv
// RV32I data memory with MMIO input/output word channels, change events and irq.
module data_mem_mmio
    import dmem_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int NUM_IN    = 2,
    parameter int NUM_OUT   = 2,
    parameter int MMIO_BASE = 'hE0
) (
    input  logic                  clk,
    input  logic                  rst,
    data_mem_mmio_if.slave        bus,
    input  logic [NUM_IN*32-1:0]  in_word_i,
    output logic [NUM_OUT*32-1:0] out_word_o,
    output logic                  irq_o
);
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(MMIO_BASE);

    logic [1:0]        off;
    logic              is_mmio;
    logic [ADDR_W-3:0] mmio_idx;
    logic              fault_d;
    logic              acc_ok;
    logic [3:0]        be;
    logic [31:0]       wdata_al;
    logic [31:0]       mmio_rd;
    logic [31:0]       ram_rd;

    logic [31:0]       out_q [NUM_OUT];
    logic [31:0]       out_d [NUM_OUT];
    logic [31:0]       in_q  [NUM_IN];
    logic [NUM_IN-1:0] ev_q, ev_d;
    logic              irq_q;

    logic              ack_q, fault_q, ld_q, src_mmio_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [31:0]       mmio_word_q;

    assign off = bus.addr[1:0];

    always_comb begin
        is_mmio  = bus.addr >= BASE_A;
        mmio_idx = (ADDR_W-2)'((bus.addr - BASE_A) >> 2);
        fault_d  = !f3_legal(bus.funct3, bus.we) || misaligned(bus.funct3, off);
        if (is_mmio) begin
            if (int'(mmio_idx) >= NUM_IN + NUM_OUT) fault_d = 1'b1;
            else if (int'(mmio_idx) < NUM_IN && bus.we) fault_d = 1'b1;
        end
        acc_ok   = bus.req && !fault_d;
        be       = byte_en(bus.funct3, off);
        wdata_al = store_align(bus.funct3, bus.wdata);
    end

    always_comb begin
        mmio_rd = 32'h0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (int'(mmio_idx) == k) mmio_rd = in_q[k];
        end
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = out_q[k];
            if (int'(mmio_idx) == NUM_IN + k) mmio_rd = out_q[k];
            if (acc_ok && bus.we && is_mmio && int'(mmio_idx) == NUM_IN + k) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) out_d[k][8*b +: 8] = wdata_al[8*b +: 8];
                end
            end
        end
        // A change seen on the same edge as a clearing load keeps the flag set.
        for (int k = 0; k < NUM_IN; k++) begin
            ev_d[k] = (in_word_i[32*k +: 32] != in_q[k]) ||
                      (ev_q[k] && !(acc_ok && !bus.we && is_mmio && int'(mmio_idx) == k));
        end
    end

    dmem_ram_bank #(.AW(ADDR_W-2)) u_ram (
        .clk     (clk),
        .addr_i  (bus.addr[ADDR_W-1:2]),
        .we_i    (acc_ok && bus.we && !is_mmio),
        .be_i    (be),
        .wdata_i (wdata_al),
        .re_i    (acc_ok && !bus.we && !is_mmio),
        .rdata_o (ram_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q       <= 1'b0;
            fault_q     <= 1'b0;
            ld_q        <= 1'b0;
            src_mmio_q  <= 1'b0;
            f3_q        <= 3'b0;
            off_q       <= 2'b0;
            mmio_word_q <= 32'h0;
            ev_q        <= '0;
            irq_q       <= 1'b0;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= 32'h0;
            for (int k = 0; k < NUM_IN; k++)  in_q[k]  <= 32'h0;
        end else begin
            ack_q       <= bus.req;
            fault_q     <= bus.req && fault_d;
            ld_q        <= acc_ok && !bus.we;
            src_mmio_q  <= is_mmio;
            f3_q        <= bus.funct3;
            off_q       <= off;
            mmio_word_q <= mmio_rd;
            ev_q        <= ev_d;
            irq_q       <= |ev_q;
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= out_d[k];
            for (int k = 0; k < NUM_IN; k++)  in_q[k]  <= in_word_i[32*k +: 32];
        end
    end

    assign bus.ack   = ack_q;
    assign bus.fault = fault_q;
    assign bus.rdata = ld_q ? load_extend(src_mmio_q ? mmio_word_q : ram_rd, f3_q, off_q) : 32'h0;
    assign irq_o     = irq_q;

    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) out_word_o[32*k +: 32] = out_q[k];
    end
endmodule

// File: tb/tb_data_mem_mmio.sv
// Directed plus randomized bench for data_mem_mmio against a byte-level reference model.
module tb_data_mem_mmio;
  localparam int NUM_IN  = 2;
  localparam int NUM_OUT = 2;
  localparam int BASE    = 'hE0;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] in_word;
  logic [63:0] out_word;
  logic        irq;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0]  ram_m [BASE];
  logic [31:0] out_m [NUM_OUT];
  logic [31:0] in_m  [NUM_IN];
  bit          ev_m  [NUM_IN];
  bit          irq_m;
  bit          exp_ack, exp_fault;
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata;
  logic        last_fault;
  logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  data_mem_mmio_if #(.ADDR_W(8)) bus ();

  data_mem_mmio #(.ADDR_W(8), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .MMIO_BASE(BASE)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .in_word_i  (in_word),
    .out_word_o (out_word),
    .irq_o      (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge worth of the specified behaviour, applied at byte granularity.
  task automatic model_edge(input bit rq, input bit we, input logic [2:0] f3,
                            input logic [7:0] a, input logic [31:0] d);
    int size, idx, ba;
    bit sgn, bad, irq_nx;
    bit [NUM_IN-1:0] chg;
    logic [31:0] val, w;
    irq_nx = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      irq_nx |= ev_m[k];
      chg[k] = (in_word[32*k +: 32] != in_m[k]);
    end
    exp_ack = rq; exp_fault = 1'b0; exp_rdata = 32'h0;
    if (rq) begin
      bad = 1'b0; sgn = 1'b0; size = 1;
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: bad = 1'b1;
      endcase
      if (we && (f3 == 3'd4 || f3 == 3'd5)) bad = 1'b1;
      if ((int'(a) % size) != 0) bad = 1'b1;
      idx = (int'(a) - BASE) / 4;
      if (int'(a) >= BASE) begin
        if (idx >= NUM_IN + NUM_OUT) bad = 1'b1;
        else if (idx < NUM_IN && we) bad = 1'b1;
      end
      exp_fault = bad;
      if (!bad) begin
        val = 32'h0;
        for (int i = 0; i < size; i++) begin
          ba = int'(a) + i;
          if (we) begin
            if (ba < BASE) ram_m[ba] = d[8*i +: 8];
            else out_m[idx-NUM_IN][8*(ba%4) +: 8] = d[8*i +: 8];
          end else begin
            if (ba < BASE) val[8*i +: 8] = ram_m[ba];
            else begin
              w = (idx < NUM_IN) ? in_m[idx] : out_m[idx-NUM_IN];
              val[8*i +: 8] = w[8*(ba%4) +: 8];
            end
          end
        end
        if (!we) begin
          if (sgn && val[8*size-1]) for (int j = 8*size; j < 32; j++) val[j] = 1'b1;
          exp_rdata = val;
          if (int'(a) >= BASE && idx < NUM_IN) ev_m[idx] = 1'b0;
        end
      end
    end
    for (int k = 0; k < NUM_IN; k++) begin
      if (chg[k]) begin
        ev_m[k] = 1'b1;
        in_m[k] = in_word[32*k +: 32];
      end
    end
    irq_m = irq_nx;
  endtask

  task automatic cycle(input bit rq, input bit we, input logic [2:0] f3,
                       input logic [7:0] a, input logic [31:0] d);
    bus.req = rq; bus.we = we; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    @(posedge clk);
    model_edge(rq, we, f3, a, d);
    #1;
    check("ack", {31'b0, bus.ack}, {31'b0, exp_ack});
    check("fault", {31'b0, bus.fault}, {31'b0, exp_fault});
    check("rdata", bus.rdata, exp_rdata);
    check("out0", out_word[31:0], out_m[0]);
    check("out1", out_word[63:32], out_m[1]);
    check("irq", {31'b0, irq}, {31'b0, irq_m});
    last_rdata = bus.rdata;
    last_fault = bus.fault;
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 32'h0);
  endtask

  initial begin
    bit          rq, we;
    logic [2:0]  f3;
    logic [7:0]  a;
    rst = 1'b1; in_word = 64'h0;
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 8'h0; bus.wdata = 32'h0;
    for (int k = 0; k < NUM_OUT; k++) out_m[k] = 32'h0;
    for (int k = 0; k < NUM_IN; k++) begin in_m[k] = 32'h0; ev_m[k] = 1'b0; end
    irq_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack", {31'b0, bus.ack}, 32'h0);
    check("rst_fault", {31'b0, bus.fault}, 32'h0);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_out", out_word[31:0] | out_word[63:32], 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < BASE / 4; i++) cycle(1'b1, 1'b1, 3'd2, 8'(4*i), $urandom);

    cycle(1'b1, 1'b1, 3'd2, 8'h10, 32'h8000_00FF);
    cycle(1'b1, 1'b0, 3'd0, 8'h10, 32'h0);
    check("lb_sext", last_rdata, 32'hFFFF_FFFF);
    check("lb_nofault", {31'b0, last_fault}, 32'h0);
    cycle(1'b1, 1'b0, 3'd4, 8'h10, 32'h0);
    check("lbu_zext", last_rdata, 32'h0000_00FF);
    cycle(1'b1, 1'b0, 3'd2, 8'h10, 32'h0);
    check("lw", last_rdata, 32'h8000_00FF);

    cycle(1'b1, 1'b1, 3'd2, 8'h20, 32'h1122_3344);
    cycle(1'b1, 1'b1, 3'd1, 8'h22, 32'h0000_BEEF);
    cycle(1'b1, 1'b0, 3'd2, 8'h20, 32'h0);
    check("sh_lanes", last_rdata, 32'hBEEF_3344);
    cycle(1'b1, 1'b0, 3'd5, 8'h21, 32'h0);
    check("lhu_misal_fault", {31'b0, last_fault}, 32'h1);
    check("lhu_misal_rdata", last_rdata, 32'h0);

    cycle(1'b1, 1'b1, 3'd2, 8'hE8, 32'h0000_0057);
    check("out0_sw", out_word[31:0], 32'h57);
    cycle(1'b1, 1'b1, 3'd2, 8'hE0, 32'h1234_5678);
    check("sw_in_fault", {31'b0, last_fault}, 32'h1);
    check("sw_in_out0", out_word[31:0], 32'h57);
    cycle(1'b1, 1'b0, 3'd2, 8'hF0, 32'h0);
    check("unmapped_fault", {31'b0, last_fault}, 32'h1);

    in_word[63:32] = 32'h5A;
    idle();
    idle();
    check("irq_set", {31'b0, irq}, 32'h1);
    cycle(1'b1, 1'b0, 3'd2, 8'hE4, 32'h0);
    check("in1_load", last_rdata, 32'h5A);
    idle();
    check("irq_clear", {31'b0, irq}, 32'h0);
    in_word[63:32] = 32'h33;
    cycle(1'b1, 1'b0, 3'd2, 8'hE4, 32'h0);
    check("in1_load_old", last_rdata, 32'h5A);
    idle();
    check("irq_set_wins", {31'b0, irq}, 32'h1);
    cycle(1'b1, 1'b0, 3'd2, 8'hE4, 32'h0);
    check("in1_load_new", last_rdata, 32'h33);
    idle();

    cycle(1'b1, 1'b1, 3'd2, 8'h40, 32'd90);
    cycle(1'b1, 1'b1, 3'd2, 8'h44, 32'd91);
    cycle(1'b1, 1'b0, 3'd2, 8'h40, 32'h0);
    check("b2b_rd0", last_rdata, 32'd90);
    cycle(1'b1, 1'b0, 3'd2, 8'h44, 32'h0);
    check("b2b_rd1", last_rdata, 32'd91);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 5) == 0) in_word[32*$urandom_range(0, 1) +: 32] = $urandom;
      rq = ($urandom_range(0, 7) != 0);
      we = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 4) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = legal_f3[$urandom_range(0, 4)];
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3 == 3'd1 || f3 == 3'd5) a[0] = 1'b0;
        if (f3 == 3'd2) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 3) == 0) a[7:4] = 4'hE;
      cycle(rq, we, f3, a, $urandom);
    end

    cycle(1'b1, 1'b1, 3'd2, 8'hE8, 32'hA5A5_A5A5);
    cycle(1'b1, 1'b1, 3'd2, 8'h10, 32'hCAFE_F00D);
    cycle(1'b1, 1'b0, 3'd2, 8'h10, 32'h0);
    check("pre_rst_rdata", last_rdata, 32'hCAFE_F00D);
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_ack", {31'b0, bus.ack}, 32'h0);
    check("midrst_rdata", bus.rdata, 32'h0);
    check("midrst_out0", out_word[31:0], 32'h0);
    check("midrst_out1", out_word[63:32], 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_ack", {31'b0, bus.ack}, 32'h0);
    check("rst_hold_irq", {31'b0, irq}, 32'h0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
